// File: rtl/gray_conv_arbiter_if.sv
// Request/response bundle between the conversion requesters and the shared
// binary/Gray conversion arbiter.
interface gray_conv_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_dir;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [WIDTH-1:0]      rsp_data;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_ready;
    logic [15:0]           conv_count;

    modport master (
        output req_valid, req_data, req_dir, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, conv_count
    );

    modport slave (
        input  req_valid, req_data, req_dir, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, conv_count
    );
endinterface

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one binary<->Gray conversion engine among NREQ
// requesters; Gray-to-binary resolves one bit per cycle, MSB first.
module gray_conv_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
) (
    input  logic               clk,
    input  logic               rst,
    gray_conv_arbiter_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH - 1) : 1;

    typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;

    state_t           state;
    logic [IDW-1:0]   last_grant;
    logic             dir;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    cnt;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic [IDW-1:0]   rsp_id;
    logic [15:0]      count;

    logic [IDW-1:0]   start;
    logic [NREQ-1:0]  rot;
    logic [IDW-1:0]   pos;
    logic             found;
    logic [31:0]      win_sum;
    logic [IDW-1:0]   win;
    logic             any;
    logic [WIDTH-1:0] sel_data;
    logic             sel_dir;
    logic [NREQ-1:0]  grant;

    // Rotate valids so the slot after last_grant sits at bit 0, take the
    // lowest set bit, then rotate the position back to a requester index.
    always_comb begin
        start = (last_grant == IDW'(NREQ - 1)) ? '0 : last_grant + IDW'(1);
        rot   = NREQ'({bus.req_valid, bus.req_valid} >> start);
        any   = |bus.req_valid;
        pos   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && rot[i]) begin
                pos   = IDW'(i);
                found = 1'b1;
            end
        end
        win_sum = 32'(pos) + 32'(start);
        win     = IDW'((win_sum >= 32'(NREQ)) ? win_sum - 32'(NREQ) : win_sum);

        sel_data = '0;
        sel_dir  = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDW'(i) == win) begin
                sel_data = bus.req_data[i*WIDTH +: WIDTH];
                sel_dir  = bus.req_dir[i];
            end
        end

        grant = '0;
        if (state == IDLE && any) begin
            grant = NREQ'(1) << win;
        end

        // work holds the remaining Gray bits left-aligned; acc shifts in b[k].
        acc_next = {acc[WIDTH-2:0], acc[0] ^ work[WIDTH-1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IDW'(NREQ - 1);
            dir        <= 1'b0;
            work       <= '0;
            acc        <= '0;
            cnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= '0;
            count      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        last_grant <= win;
                        dir        <= sel_dir;
                        cnt        <= CW'(WIDTH - 2);
                        if (sel_dir) begin
                            work <= sel_data << 1;
                            acc  <= {{(WIDTH-1){1'b0}}, sel_data[WIDTH-1]};
                        end else begin
                            work <= sel_data;
                        end
                        state <= CONV;
                    end
                end
                CONV: begin
                    if (!dir) begin
                        rsp_data  <= work ^ (work >> 1);
                        rsp_id    <= last_grant;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        acc  <= acc_next;
                        work <= work << 1;
                        if (cnt == '0) begin
                            rsp_data  <= acc_next;
                            rsp_id    <= last_grant;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid <= 1'b0;
                        count     <= count + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = grant;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_data   = rsp_data;
    assign bus.rsp_id     = rsp_id;
    assign bus.conv_count = count;
endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench for gray_conv_arbiter: directed table, hand sequences
// for reset/backpressure/fairness/wrap, and randomized traffic against a model.
module tb_gray_conv_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gray_conv_arbiter_if #(.NREQ(NREQ), .WIDTH(W), .IDW(IDW)) bus ();

    gray_conv_arbiter #(.NREQ(NREQ), .WIDTH(W), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned total  = 0;
    int unsigned passed = 0;

    logic [NREQ-1:0] pv;
    logic [NREQ-1:0] pdir;
    logic [W-1:0]    pd [NREQ];
    int              lg;
    logic [15:0]     exp_count;

    typedef struct {
        int           id;
        logic         dir;
        logic [W-1:0] din;
        logic [W-1:0] dout;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    function automatic logic [W-1:0] b2g(input logic [W-1:0] d);
        return d ^ (d >> 1);
    endfunction

    // Binary bit k is the XOR of all Gray bits at or above k.
    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b = '0;
        for (int s = 0; s < W; s++) b ^= g >> s;
        return b;
    endfunction

    function automatic int pick(input logic [NREQ-1:0] m, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (m[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic drive();
        bus.req_valid = pv;
        bus.req_dir   = pdir;
        for (int i = 0; i < NREQ; i++) bus.req_data[i*W +: W] = pd[i];
        #1;
    endtask

    // Called at a quiet point in IDLE with requests driven. bp < 0 raises
    // rsp_ready before the response appears; bp > 0 stalls that many cycles.
    task automatic txn(input int bp, output logic [W-1:0] got, output int got_id);
        int           w;
        int           edges;
        int           lat;
        logic [W-1:0] exp_d;
        w = pick(pv, lg);
        if (w < 0) begin
            check("grant_none", 32'(bus.req_ready), 0);
            got    = '0;
            got_id = -1;
            return;
        end
        check("grant", 32'(bus.req_ready), 32'(1) << w);
        exp_d = pdir[w] ? g2b(pd[w]) : b2g(pd[w]);
        lat   = pdir[w] ? W : 2;
        @(posedge clk);
        lg = w;
        @(negedge clk);
        pv[w] = 1'b0;
        bus.rsp_ready = (bp < 0);
        drive();
        edges = 1;
        while (!bus.rsp_valid && edges < 40) begin
            check("ready_busy", 32'(bus.req_ready), 0);
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("latency", edges, lat);
        check("rsp_data", 32'(bus.rsp_data), 32'(exp_d));
        check("rsp_id", 32'(bus.rsp_id), w);
        got    = bus.rsp_data;
        got_id = int'(bus.rsp_id);
        for (int c = 0; c < bp; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", 32'(bus.rsp_valid), 1);
            check("hold_data", 32'(bus.rsp_data), 32'(exp_d));
            check("hold_id", 32'(bus.rsp_id), w);
            check("hold_count", 32'(bus.conv_count), 32'(exp_count));
            check("hold_ready", 32'(bus.req_ready), 0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        exp_count++;
        check("rsp_done", 32'(bus.rsp_valid), 0);
        check("count", 32'(bus.conv_count), 32'(exp_count));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] got;
        logic [W-1:0] g;
        int           gid;

        rst = 1'b1;
        pv = '0;
        pdir = '0;
        for (int i = 0; i < NREQ; i++) pd[i] = '0;
        bus.rsp_ready = 1'b0;
        drive();
        lg = NREQ - 1;
        exp_count = '0;

        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 0);
        check("rst_valid", 32'(bus.rsp_valid), 0);
        check("rst_data", 32'(bus.rsp_data), 0);
        check("rst_id", 32'(bus.rsp_id), 0);
        check("rst_count", 32'(bus.conv_count), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready_none", 32'(bus.req_ready), 0);
        check("idle_valid", 32'(bus.rsp_valid), 0);

        vecs[0] = '{1, 1'b0, 4'b1011, 4'b1110};
        vecs[1] = '{1, 1'b0, 4'b0111, 4'b0100};
        vecs[2] = '{2, 1'b1, 4'b1110, 4'b1011};
        vecs[3] = '{2, 1'b1, 4'b1000, 4'b1111};
        vecs[4] = '{0, 1'b1, 4'b0000, 4'b0000};
        vecs[5] = '{3, 1'b0, 4'b1111, 4'b1000};
        for (int i = 0; i < 6; i++) begin
            pv = '0;
            pv[vecs[i].id]   = 1'b1;
            pd[vecs[i].id]   = vecs[i].din;
            pdir[vecs[i].id] = vecs[i].dir;
            drive();
            check("tbl_ready", 32'(bus.req_ready), 32'(1) << vecs[i].id);
            txn((i == 5) ? -1 : 0, got, gid);
            check("tbl_data", 32'(got), 32'(vecs[i].dout));
        end

        // Backpressure: five stalled RESP cycles.
        pv = '0;
        pv[3] = 1'b1;
        pd[3] = 4'b0110;
        pdir[3] = 1'b0;
        drive();
        txn(5, got, gid);
        check("bp_data", 32'(got), 32'(4'b0101));

        for (int v = 0; v < 16; v++) begin
            pv = '0;
            pv[0] = 1'b1;
            pd[0] = W'(v);
            pdir[0] = 1'b0;
            drive();
            txn(0, g, gid);
            pv[1] = 1'b1;
            pd[1] = g;
            pdir[1] = 1'b1;
            drive();
            txn(0, got, gid);
            check("roundtrip", 32'(got), v);
        end

        pv = '0;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i] && $urandom_range(0, 1) == 1) begin
                    pv[i]   = 1'b1;
                    pd[i]   = W'($urandom);
                    pdir[i] = 1'($urandom_range(0, 1));
                end
            end
            if (pv == '0) begin
                pv[0]   = 1'b1;
                pd[0]   = W'($urandom);
                pdir[0] = 1'($urandom_range(0, 1));
            end
            drive();
            txn(int'($urandom_range(0, 4)) - 1, got, gid);
        end

        // Reset in the middle of a Gray-to-binary conversion.
        pv = '0;
        pv[2] = 1'b1;
        pd[2] = 4'b1110;
        pdir[2] = 1'b1;
        drive();
        check("mr_grant", 32'(bus.req_ready), 32'(4'b0100));
        @(posedge clk);
        @(negedge clk);
        pv = '0;
        drive();
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("mr_ready", 32'(bus.req_ready), 0);
        check("mr_count", 32'(bus.conv_count), 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("mr_novalid", 32'(bus.rsp_valid), 0);
        end
        rst = 1'b0;
        lg = NREQ - 1;
        exp_count = '0;

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i]) begin
                    pv[i]   = 1'b1;
                    pd[i]   = W'($urandom);
                    pdir[i] = 1'($urandom_range(0, 1));
                end
            end
            drive();
            txn(0, got, gid);
            check("fair_order", gid, t % NREQ);
        end

        pv = '0;
        drive();
        force dut.count = 16'hFFFE;
        #1;
        release dut.count;
        #1;
        exp_count = 16'hFFFE;
        check("count_preload", 32'(bus.conv_count), 32'(16'hFFFE));
        for (int t = 0; t < 2; t++) begin
            pv[0]   = 1'b1;
            pd[0]   = W'($urandom);
            pdir[0] = 1'($urandom_range(0, 1));
            drive();
            txn(0, got, gid);
        end
        check("count_wrap", 32'(bus.conv_count), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
